// File: rtl/mem_port_arbiter_if.sv
// Bundle for mem_port_arbiter: fetch and data requesters,
// the shared memory port and port status.
interface mem_port_arbiter_if #(
   parameter int AW = 32
);
   logic          if_req;
   logic [AW-1:0] if_addr;
   logic          if_ack;
   logic [31:0]   if_rdata;

   logic          d_req;
   logic          d_we;
   logic [AW-1:0] d_addr;
   logic [31:0]   d_wdata;
   logic [3:0]    d_be;
   logic          d_ack;
   logic [31:0]   d_rdata;

   logic          mem_req;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata;
   logic [3:0]    mem_be;
   logic          mem_ack;
   logic [31:0]   mem_rdata;

   logic          mem_busy;
   logic          bus_err;

   modport slave (
      input  if_req,
      input  if_addr,
      output if_ack,
      output if_rdata,
      input  d_req,
      input  d_we,
      input  d_addr,
      input  d_wdata,
      input  d_be,
      output d_ack,
      output d_rdata,
      output mem_req,
      output mem_we,
      output mem_addr,
      output mem_wdata,
      output mem_be,
      input  mem_ack,
      input  mem_rdata,
      output mem_busy,
      output bus_err
   );

   modport master (
      output if_req,
      output if_addr,
      input  if_ack,
      input  if_rdata,
      output d_req,
      output d_we,
      output d_addr,
      output d_wdata,
      output d_be,
      input  d_ack,
      input  d_rdata,
      input  mem_req,
      input  mem_we,
      input  mem_addr,
      input  mem_wdata,
      input  mem_be,
      output mem_ack,
      output mem_rdata,
      input  mem_busy,
      input  bus_err
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one data-memory port between fetch and load/store,
// with a one-deep posted write buffer and a transfer watchdog.
module mem_port_arbiter #(
   parameter int AW      = 32,
   parameter int TIMEOUT = 64
) (
   input  logic              clk,
   input  logic              rst,
   mem_port_arbiter_if.slave bus
);
   localparam int CW =
      (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam bit WD_EN = (TIMEOUT != 0);
   localparam logic [CW-1:0] WD_LAST =
      CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
   localparam logic [31:0] ABORT_DATA = 32'hDEADBEEF;

   typedef enum logic [1:0] {
      IDLE,
      RD_IF,
      RD_D,
      WR
   } state_t;

   state_t        state;
   state_t        gnt;
   logic          wbuf_valid;
   logic [AW-1:0] wbuf_addr;
   logic [31:0]   wbuf_wdata;
   logic [3:0]    wbuf_be;
   logic          last_grant_data;
   logic [CW-1:0] wd_cnt;

   logic          if_elig;
   logic          rd_elig;
   logic          wr_cap;
   logic          wd_fire;
   logic          done;
   logic [31:0]   done_data;

   assign if_elig = bus.if_req && !bus.if_ack;
   assign rd_elig = bus.d_req && !bus.d_we && !bus.d_ack;
   assign wr_cap  = !wbuf_valid && bus.d_req
                    && bus.d_we && !bus.d_ack;
   assign wd_fire = WD_EN && (wd_cnt == WD_LAST);
   // A real ack on the timeout cycle still completes normally.
   assign done      = bus.mem_ack || wd_fire;
   assign done_data = bus.mem_ack ? bus.mem_rdata
                                  : ABORT_DATA;

   assign bus.mem_busy = (state != IDLE) || wbuf_valid;

   // Draining the buffer ahead of data reads keeps RAW order.
   always_comb begin
      gnt = IDLE;
      if (if_elig && last_grant_data)
         gnt = RD_IF;
      else if (wbuf_valid)
         gnt = WR;
      else if (rd_elig)
         gnt = RD_D;
      else if (if_elig)
         gnt = RD_IF;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state           <= IDLE;
         wbuf_valid      <= 1'b0;
         wbuf_addr       <= '0;
         wbuf_wdata      <= '0;
         wbuf_be         <= '0;
         last_grant_data <= 1'b0;
         wd_cnt          <= '0;
         bus.if_ack      <= 1'b0;
         bus.if_rdata    <= '0;
         bus.d_ack       <= 1'b0;
         bus.d_rdata     <= '0;
         bus.mem_req     <= 1'b0;
         bus.mem_we      <= 1'b0;
         bus.mem_addr    <= '0;
         bus.mem_wdata   <= '0;
         bus.mem_be      <= '0;
         bus.bus_err     <= 1'b0;
      end else begin
         bus.if_ack  <= 1'b0;
         bus.d_ack   <= 1'b0;
         bus.bus_err <= 1'b0;

         if (wr_cap) begin
            wbuf_valid <= 1'b1;
            wbuf_addr  <= bus.d_addr;
            wbuf_wdata <= bus.d_wdata;
            wbuf_be    <= bus.d_be;
            bus.d_ack  <= 1'b1;
         end

         unique case (state)
            IDLE: begin
               state   <= gnt;
               wd_cnt  <= '0;
               bus.mem_req <= (gnt != IDLE);
               unique case (gnt)
                  RD_IF: begin
                     last_grant_data <= 1'b0;
                     bus.mem_we      <= 1'b0;
                     bus.mem_addr    <= bus.if_addr;
                     bus.mem_be      <= 4'hF;
                  end
                  RD_D: begin
                     last_grant_data <= 1'b1;
                     bus.mem_we      <= 1'b0;
                     bus.mem_addr    <= bus.d_addr;
                     bus.mem_be      <= 4'hF;
                  end
                  WR: begin
                     last_grant_data <= 1'b1;
                     bus.mem_we      <= 1'b1;
                     bus.mem_addr    <= wbuf_addr;
                     bus.mem_wdata   <= wbuf_wdata;
                     bus.mem_be      <= wbuf_be;
                  end
                  default: ;
               endcase
            end
            default: begin
               if (done) begin
                  state       <= IDLE;
                  bus.mem_req <= 1'b0;
                  bus.mem_we  <= 1'b0;
                  bus.bus_err <= !bus.mem_ack;
                  unique case (state)
                     RD_IF: begin
                        bus.if_ack   <= 1'b1;
                        bus.if_rdata <= done_data;
                     end
                     RD_D: begin
                        bus.d_ack   <= 1'b1;
                        bus.d_rdata <= done_data;
                     end
                     default: wbuf_valid <= 1'b0;
                  endcase
               end else if (WD_EN) begin
                  wd_cnt <= wd_cnt + 1'b1;
               end
            end
         endcase
      end
   end
endmodule
